cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 4-bit CPU datapath.
- Decodes the 4-bit opcode and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath strobes: PC, instruction register, register file, memory, ALU op, and the MemtoReg select of the data-memory writeback mux.
- Handles memory wait states with a bounded-wait watchdog.

Parameters:
MAX_WAIT, 15, max cycles spent waiting for mem_ready in FETCH or MEM before entering ERROR (1..15).
HALT_OP, 4'hF, opcode that stops the sequencer.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
opcode  input  4  opcode field of instruction register (valid from DECODE onward)
zero  input  1  ALU zero flag (valid in EXEC)
mem_ready  input  1  memory completes current read/write this cycle
pc_write  output  1  load PC (PC+1 or branch/jump target)
pc_src  output  1  0 = PC+1, 1 = target
ir_write  output  1  load instruction register
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write enable
MemtoReg  output  1  writeback select: 0 = aluResult, 1 = readData
alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 OR
halted  output  1  sequencer in HALT
error  output  1  sequencer in ERROR (memory timeout)
state  output  3  current state encoding, for debug

Behaviour:
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LOAD, 6 STORE, 7 BEQ, 8 JMP, F HALT. Others are treated as NOP.
- State encoding:
  - FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
  - 7 is unreachable and recovers to FETCH.
- Reset (async): state=FETCH, wait counter=0. All outputs are derived from state, so immediately after reset: mem_read=1, every other strobe 0, MemtoReg=0, alu_op=00, halted=0, error=0.
- FETCH: mem_read=1.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0 (same cycle, combinational on mem_ready); next=DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: no strobes. Next state by opcode:
  - HALT_OP -> HALT.
  - NOP or undefined -> FETCH.
  - JMP -> FETCH, with pc_write=1 and pc_src=1 this cycle.
  - All others -> EXEC.
- EXEC:
  - alu_op: ADD 00, SUB 01, AND 10, OR 11; LOAD/STORE 00 (address); BEQ 01.
  - ALU ops -> WB.
  - LOAD/STORE -> MEM.
  - BEQ: pc_write=zero, pc_src=1; next=FETCH.
- MEM:
  - LOAD: mem_read=1. STORE: mem_write=1.
  - On mem_ready=1: STORE -> FETCH, LOAD -> WB.
  - Otherwise stay and increment the wait counter.
- WB: reg_write=1 for exactly one cycle.
  - MemtoReg=1 for LOAD, 0 for ALU ops.
  - Next=FETCH.
- Wait counter (4-bit):
  - Cleared on every state change.
  - If the counter reaches MAX_WAIT while still waiting, next=ERROR; the strobes of the timed-out access are not asserted.
- HALT and ERROR: absorbing, all strobes 0, halted=1 or error=1 respectively. Exit only via reset.
- mem_read and mem_write are never both 1.
- reg_write is never 1 outside WB.
- ir_write is only 1 in FETCH.
- Reset asserted mid-instruction aborts it; no strobe fires after reset asserts.
- MemtoReg is held at 0 in every state except WB-for-LOAD.

Test Plan:
1. Reset, then ADD with mem_ready=1 tied high -> states 0,1,2,4,0. reg_write=1 only in WB, MemtoReg=0, alu_op=00 in EXEC. 4 cycles per instruction.
2. LOAD with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM -> FETCH lasts 3 cycles, MEM lasts 4. WB has reg_write=1, MemtoReg=1. mem_read=1 throughout MEM.
3. STORE, then BEQ with zero=1, then BEQ with zero=0 -> STORE: mem_write=1 in MEM, reg_write never 1. BEQ taken: pc_write=1 and pc_src=1 in EXEC. BEQ not taken: pc_write=0 in EXEC.
4. JMP, then opcode 4'hF -> JMP: pc_write=1, pc_src=1 in DECODE, then FETCH. 4'hF: HALT with halted=1, mem_read=0, and the state holds for 20 cycles.
5. mem_ready held 0 in FETCH -> after MAX_WAIT=15 cycles, state=6 and error=1. Asserting reset returns to state=0 with error=0.
6. Assert reset mid-MEM of a STORE -> mem_write drops in the same cycle, state=0. The next instruction then executes normally.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 4-bit CPU: FETCH/DECODE/EXEC/MEM/WB
// with a memory wait-state watchdog that parks the machine in ERROR.
module cpu_ctrl_fsm #(
    parameter logic [3:0] MAX_WAIT = 4'd15,
    parameter logic [3:0] HALT_OP  = 4'hF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       MemtoReg,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4;
    localparam logic [3:0] OP_LOAD = 4'h5, OP_STORE = 4'h6, OP_BEQ = 4'h7, OP_JMP = 4'h8;

    state_t     curState, nextState;
    logic [3:0] waitCnt;
    logic       stalled;
    logic       timeout;
    logic       isLoad, isStore;

    assign isLoad  = (opcode == OP_LOAD);
    assign isStore = (opcode == OP_STORE);
    assign stalled = ((curState == FETCH) || (curState == MEM)) && !mem_ready;
    // The stall that would bring the counter up to MAX_WAIT is the last one allowed.
    assign timeout = stalled && (waitCnt == MAX_WAIT - 4'd1);
    assign state   = curState;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            curState <= FETCH;
            waitCnt  <= 4'd0;
        end else begin
            curState <= nextState;
            if (nextState != curState) waitCnt <= 4'd0;
            else if (stalled)          waitCnt <= waitCnt + 4'd1;
        end
    end

    always_comb begin
        nextState = curState;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        MemtoReg  = 1'b0;
        alu_op    = 2'b00;
        halted    = 1'b0;
        error     = 1'b0;
        case (curState)
            FETCH: begin
                mem_read = 1'b1;
                // Gate on reset so a ready memory cannot fire strobes while held in reset.
                if (mem_ready && !reset) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nextState = DECODE;
                end else if (timeout) begin
                    nextState = ERROR;
                end
            end
            DECODE: begin
                if (opcode == HALT_OP) begin
                    nextState = HALT;
                end else begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_LOAD, OP_STORE, OP_BEQ: nextState = EXEC;
                        OP_JMP: begin
                            pc_write  = 1'b1;
                            pc_src    = 1'b1;
                            nextState = FETCH;
                        end
                        default: nextState = FETCH;
                    endcase
                end
            end
            EXEC: begin
                case (opcode)
                    OP_SUB, OP_BEQ: alu_op = 2'b01;
                    OP_AND:         alu_op = 2'b10;
                    OP_OR:          alu_op = 2'b11;
                    default:        alu_op = 2'b00;
                endcase
                if (isLoad || isStore) begin
                    nextState = MEM;
                end else if (opcode == OP_BEQ) begin
                    pc_write  = zero;
                    pc_src    = 1'b1;
                    nextState = FETCH;
                end else begin
                    nextState = WB;
                end
            end
            MEM: begin
                mem_read  = isLoad;
                mem_write = isStore;
                if (mem_ready)    nextState = isLoad ? WB : FETCH;
                else if (timeout) nextState = ERROR;
            end
            WB: begin
                reg_write = 1'b1;
                MemtoReg  = isLoad;
                nextState = FETCH;
            end
            HALT:    halted = 1'b1;
            ERROR:   error  = 1'b1;
            default: nextState = FETCH;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: walks each instruction class cycle by cycle
// and compares state plus every strobe against hand-computed values.
module tb_cpu_ctrl_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, MemtoReg;
    logic [1:0] alu_op;
    logic       halted, error;
    logic [2:0] state;

    int total = 0;
    int fails = 0;

    cpu_ctrl_fsm #(.MAX_WAIT(4'd15), .HALT_OP(4'hF)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .MemtoReg(MemtoReg), .alu_op(alu_op),
        .halted(halted), .error(error), .state(state)
    );

    always #5 clock = ~clock;

    // Strobe vector order: pc_write pc_src ir_write mem_read mem_write reg_write MemtoReg
    task automatic chk(input string tag, input logic [2:0] st, input logic [6:0] s,
                       input logic [1:0] alu, input logic [1:0] he);
        logic [13:0] obs, exp;
        obs = {state, pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, MemtoReg,
               alu_op, halted, error};
        exp = {st, s, alu, he};
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set(input logic [3:0] op, input logic rdy, input logic z);
        opcode    = op;
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    localparam logic [6:0] S_NONE = 7'b0000000, S_FRD = 7'b0001000, S_FOK = 7'b1011000;

    initial begin
        #100000;
        $display("FAIL timeout bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
        #1 chk("reset", 3'd0, S_FRD, 2'b00, 2'b00);
        #11 reset = 1'b0;

        // ADD, memory always ready: 0,1,2,4
        set(4'h1, 1'b1, 1'b0); chk("add_fetch", 3'd0, S_FOK, 2'b00, 2'b00); step();
        chk("add_decode", 3'd1, S_NONE, 2'b00, 2'b00); step();
        chk("add_exec",   3'd2, S_NONE, 2'b00, 2'b00); step();
        chk("add_wb",     3'd4, 7'b0000010, 2'b00, 2'b00); step();

        // LOAD with 2 fetch stalls and 3 mem stalls
        set(4'h5, 1'b0, 1'b0); chk("ld_fetch_w0", 3'd0, S_FRD, 2'b00, 2'b00); step();
        chk("ld_fetch_w1", 3'd0, S_FRD, 2'b00, 2'b00); step();
        set(4'h5, 1'b1, 1'b0); chk("ld_fetch", 3'd0, S_FOK, 2'b00, 2'b00); step();
        chk("ld_decode", 3'd1, S_NONE, 2'b00, 2'b00); step();
        chk("ld_exec",   3'd2, S_NONE, 2'b00, 2'b00); step();
        set(4'h5, 1'b0, 1'b0); chk("ld_mem_w0", 3'd3, S_FRD, 2'b00, 2'b00); step();
        chk("ld_mem_w1", 3'd3, S_FRD, 2'b00, 2'b00); step();
        chk("ld_mem_w2", 3'd3, S_FRD, 2'b00, 2'b00); step();
        set(4'h5, 1'b1, 1'b0); chk("ld_mem", 3'd3, S_FRD, 2'b00, 2'b00); step();
        chk("ld_wb", 3'd4, 7'b0000011, 2'b00, 2'b00); step();

        // STORE
        set(4'h6, 1'b1, 1'b0); chk("st_fetch", 3'd0, S_FOK, 2'b00, 2'b00); step();
        chk("st_decode", 3'd1, S_NONE, 2'b00, 2'b00); step();
        chk("st_exec",   3'd2, S_NONE, 2'b00, 2'b00); step();
        chk("st_mem",    3'd3, 7'b0000100, 2'b00, 2'b00); step();

        // BEQ taken, then not taken
        set(4'h7, 1'b1, 1'b1); chk("beq1_fetch", 3'd0, S_FOK, 2'b00, 2'b00); step();
        chk("beq1_decode", 3'd1, S_NONE, 2'b00, 2'b00); step();
        chk("beq1_exec",   3'd2, 7'b1100000, 2'b01, 2'b00); step();
        set(4'h7, 1'b1, 1'b0); chk("beq0_fetch", 3'd0, S_FOK, 2'b00, 2'b00); step();
        chk("beq0_decode", 3'd1, S_NONE, 2'b00, 2'b00); step();
        chk("beq0_exec",   3'd2, 7'b0100000, 2'b01, 2'b00); step();

        // SUB / AND / OR alu_op in EXEC
        set(4'h2, 1'b1, 1'b0); step(); step(); chk("sub_exec", 3'd2, S_NONE, 2'b01, 2'b00); step(); step();
        set(4'h3, 1'b1, 1'b0); step(); step(); chk("and_exec", 3'd2, S_NONE, 2'b10, 2'b00); step(); step();
        set(4'h4, 1'b1, 1'b0); step(); step(); chk("or_exec",  3'd2, S_NONE, 2'b11, 2'b00); step(); step();

        // Undefined opcode behaves as NOP
        set(4'hA, 1'b1, 1'b0); step(); chk("undef_decode", 3'd1, S_NONE, 2'b00, 2'b00); step();
        chk("undef_back", 3'd0, S_FOK, 2'b00, 2'b00);

        // JMP then HALT
        set(4'h8, 1'b1, 1'b0); chk("jmp_fetch", 3'd0, S_FOK, 2'b00, 2'b00); step();
        chk("jmp_decode", 3'd1, 7'b1100000, 2'b00, 2'b00); step();
        set(4'hF, 1'b1, 1'b0); chk("hlt_fetch", 3'd0, S_FOK, 2'b00, 2'b00); step();
        chk("hlt_decode", 3'd1, S_NONE, 2'b00, 2'b00); step();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("halt_hold%0d", i), 3'd5, S_NONE, 2'b00, 2'b10);
            step();
        end

        // Watchdog: 15 stalled fetch cycles then ERROR
        set(4'h0, 1'b0, 1'b0);
        reset = 1'b1; #1;
        chk("rst_from_halt", 3'd0, S_FRD, 2'b00, 2'b00);
        reset = 1'b0;
        repeat (14) step();
        chk("wd_fetch_last", 3'd0, S_FRD, 2'b00, 2'b00); step();
        chk("wd_error", 3'd6, S_NONE, 2'b00, 2'b01);
        set(4'h1, 1'b1, 1'b0); step();
        chk("wd_error_hold", 3'd6, S_NONE, 2'b00, 2'b01);
        reset = 1'b1; #1;
        chk("rst_from_error", 3'd0, S_FRD, 2'b00, 2'b00);
        reset = 1'b0;

        // Reset mid-MEM of a STORE, then a normal ADD
        set(4'h6, 1'b1, 1'b0); step(); step(); step();
        set(4'h6, 1'b0, 1'b0); chk("st2_mem", 3'd3, 7'b0000100, 2'b00, 2'b00);
        reset = 1'b1; #1;
        chk("st2_reset", 3'd0, S_FRD, 2'b00, 2'b00);
        reset = 1'b0;
        set(4'h1, 1'b1, 1'b0); chk("add2_fetch", 3'd0, S_FOK, 2'b00, 2'b00); step();
        chk("add2_decode", 3'd1, S_NONE, 2'b00, 2'b00); step();
        chk("add2_exec",   3'd2, S_NONE, 2'b00, 2'b00); step();
        chk("add2_wb",     3'd4, 7'b0000010, 2'b00, 2'b00); step();
        chk("add2_next",   3'd0, S_FOK, 2'b00, 2'b00);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
